spi_slave_core: RTL and testbench

Parametrised SPI slave for the mixed-signal test chips: configurable word width, all four SPI modes (CPOL/CPHA), back-to-back words within one chip-select frame, and a frame-error flag. All SPI pins are synchronised into `clk`; no SPI-derived clock or asynchronous set/reset is used inside the block. It sits between the external SPI pads and the register-file / command decoder, and is the successor to the mode-0, 8-bit-only slave.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_sync.sv | 21 ++
 rtl/spi_slave_core.sv | 145 ++++++++++++++
 tb/tb_spi_slave_core.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI slave core
package spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

  // {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic bit width_ok(input int w);
    return (w >= 2) && (w <= 32);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - N-stage synchroniser with configurable reset value
module spi_sync #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ff <= {STAGES{RST_VAL}};
    else         ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave_core.sv
// rtl/spi_slave_core.sv - oversampled SPI slave, all modes, parametrised word width
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             SPI_CS,
  input  logic             SPI_Clk,
  input  logic             SPI_MOSI,
  output logic             SPI_MISO,
  output logic             Rx_DV,
  output logic [WIDTH-1:0] Rx_Byte,
  input  logic [WIDTH-1:0] Tx_Byte,
  output logic             Tx_Load,
  output logic             Frame_Err,
  output logic             Busy
);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("spi_slave_core: WIDTH must be in 2..32");
  end

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic cs_s, sck_s, mosi_s, cs_d, sck_d;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .resetn(resetn), .d(SPI_CS),   .q(cs_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sck  (.clk(clk), .resetn(resetn), .d(SPI_Clk),  .q(sck_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .resetn(resetn), .d(SPI_MOSI), .q(mosi_s));

  spi_state_t       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] rx_shift, rx_shift_nxt, tx_shift, tx_shift_nxt, rx_byte, rx_byte_nxt;
  logic             rx_dv, rx_dv_nxt, tx_load, tx_load_nxt, frame_err, frame_err_nxt;
  logic             reload, reload_nxt, armed, armed_nxt;
  // prime[k] is set once sync stage k holds a real pin sample rather than its reset value
  logic [SYNC_STAGES-1:0] prime;

  logic lead_edge, trail_edge, sample_edge, shift_edge, cs_fall, cs_rise;

  assign lead_edge   = (sck_s != CPOL) && (sck_d == CPOL);
  assign trail_edge  = (sck_s == CPOL) && (sck_d != CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;
  assign cs_fall     = cs_d && !cs_s;
  assign cs_rise     = !cs_d && cs_s;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cs_d      <= 1'b1;
      sck_d     <= CPOL;
      prime     <= '0;
      state     <= ST_IDLE;
      cnt       <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      rx_byte   <= '0;
      rx_dv     <= 1'b0;
      tx_load   <= 1'b0;
      frame_err <= 1'b0;
      reload    <= 1'b0;
      armed     <= 1'b0;
    end else begin
      cs_d      <= cs_s;
      sck_d     <= sck_s;
      prime     <= {prime[SYNC_STAGES-2:0], 1'b1};
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rx_shift  <= rx_shift_nxt;
      tx_shift  <= tx_shift_nxt;
      rx_byte   <= rx_byte_nxt;
      rx_dv     <= rx_dv_nxt;
      tx_load   <= tx_load_nxt;
      frame_err <= frame_err_nxt;
      reload    <= reload_nxt;
      armed     <= armed_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    rx_shift_nxt  = rx_shift;
    tx_shift_nxt  = tx_shift;
    rx_byte_nxt   = rx_byte;
    rx_dv_nxt     = 1'b0;
    tx_load_nxt   = 1'b0;
    frame_err_nxt = 1'b0;
    reload_nxt    = reload;
    armed_nxt     = armed || (prime[SYNC_STAGES-1] && cs_s);
    case (state)
      ST_IDLE: begin
        if (cs_fall && armed) begin
          state_nxt  = ST_ACTIVE;
          cnt_nxt    = '0;
          reload_nxt = 1'b0;
          if (!CPHA) begin
            tx_shift_nxt = Tx_Byte;
            tx_load_nxt  = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        // CS deassertion takes priority over any SCK edge seen in the same cycle
        if (cs_rise) begin
          state_nxt     = ST_IDLE;
          frame_err_nxt = (cnt != '0);
        end else if (sample_edge) begin
          rx_shift_nxt = {rx_shift[WIDTH-2:0], mosi_s};
          if (cnt == LAST) begin
            cnt_nxt     = '0;
            rx_byte_nxt = {rx_shift[WIDTH-2:0], mosi_s};
            rx_dv_nxt   = 1'b1;
            reload_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else if (shift_edge) begin
          if (CPHA ? (cnt == '0) : reload) begin
            tx_shift_nxt = Tx_Byte;
            tx_load_nxt  = 1'b1;
            reload_nxt   = 1'b0;
          end else begin
            tx_shift_nxt = {tx_shift[WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign SPI_MISO  = tx_shift[WIDTH-1];
  assign Rx_DV     = rx_dv;
  assign Rx_Byte   = rx_byte;
  assign Tx_Load   = tx_load;
  assign Frame_Err = frame_err;
  assign Busy      = (state == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave_core.sv
// tb/tb_spi_slave_core.sv - directed bench: mode 0 / mode 3 x16 / mode 1 slaves driven by a bit-level master
module tb_spi_slave_core;
  import spi_pkg::*;

  localparam int H = 40;  // SCK half period, 4 clk -> ratio 8

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [2:0]  cs_p, sck_p, mosi_p;
  wire  [2:0]  miso_p, rx_dv, tx_load, frame_err, busy;
  wire  [7:0]  rx_byte0, rx_byte2;
  wire  [15:0] rx_byte1;
  logic [7:0]  tx_byte0, tx_byte2;
  logic [15:0] tx_byte1;

  spi_slave_core #(.WIDTH(8), .CPOL(MODE0[1]), .CPHA(MODE0[0]), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .resetn(resetn), .SPI_CS(cs_p[0]), .SPI_Clk(sck_p[0]), .SPI_MOSI(mosi_p[0]),
    .SPI_MISO(miso_p[0]), .Rx_DV(rx_dv[0]), .Rx_Byte(rx_byte0), .Tx_Byte(tx_byte0),
    .Tx_Load(tx_load[0]), .Frame_Err(frame_err[0]), .Busy(busy[0]));

  spi_slave_core #(.WIDTH(16), .CPOL(MODE3[1]), .CPHA(MODE3[0]), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .resetn(resetn), .SPI_CS(cs_p[1]), .SPI_Clk(sck_p[1]), .SPI_MOSI(mosi_p[1]),
    .SPI_MISO(miso_p[1]), .Rx_DV(rx_dv[1]), .Rx_Byte(rx_byte1), .Tx_Byte(tx_byte1),
    .Tx_Load(tx_load[1]), .Frame_Err(frame_err[1]), .Busy(busy[1]));

  spi_slave_core #(.WIDTH(8), .CPOL(MODE1[1]), .CPHA(MODE1[0]), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .resetn(resetn), .SPI_CS(cs_p[2]), .SPI_Clk(sck_p[2]), .SPI_MOSI(mosi_p[2]),
    .SPI_MISO(miso_p[2]), .Rx_DV(rx_dv[2]), .Rx_Byte(rx_byte2), .Tx_Byte(tx_byte2),
    .Tx_Load(tx_load[2]), .Frame_Err(frame_err[2]), .Busy(busy[2]));

  // Host side: the word presented on Tx_Byte advances each time a Tx_Load pulse is seen
  logic [31:0] tx_list [3][256];
  int          tx_base [3];
  int          n_dv [3], n_load [3], n_err [3];
  logic [31:0] rx_log [3][1024];

  assign tx_byte0 = tx_list[0][(n_load[0] - tx_base[0]) & 255][7:0];
  assign tx_byte1 = tx_list[1][(n_load[1] - tx_base[1]) & 255][15:0];
  assign tx_byte2 = tx_list[2][(n_load[2] - tx_base[2]) & 255][7:0];

  always @(negedge clk) begin
    if (rx_dv[0]) rx_log[0][n_dv[0] & 1023] = {24'h0, rx_byte0};
    if (rx_dv[1]) rx_log[1][n_dv[1] & 1023] = {16'h0, rx_byte1};
    if (rx_dv[2]) rx_log[2][n_dv[2] & 1023] = {24'h0, rx_byte2};
    for (int i = 0; i < 3; i++) begin
      if (rx_dv[i])     n_dv[i]++;
      if (tx_load[i])   n_load[i]++;
      if (frame_err[i]) n_err[i]++;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_tx[$], m_rx[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Master: sends m_tx words MSB first, collects MISO into m_rx; last word may be truncated
  task automatic frame(input int k, input bit cpol, input bit cpha, input int width,
                       input int nwords, input int last_bits);
    logic [31:0] word, got;
    int nb;
    bit first;
    first = 1'b1;
    cs_p[k] = 1'b0;
    #H;
    for (int w = 0; w < nwords; w++) begin
      nb   = (w == nwords - 1) ? last_bits : width;
      word = m_tx[w];
      got  = '0;
      for (int b = 0; b < nb; b++) begin
        if (!cpha) begin
          if (!first) sck_p[k] = cpol;
          mosi_p[k] = word[width-1-b];
          #H;
          got = {got[30:0], miso_p[k]};
          sck_p[k] = ~cpol;
          #H;
        end else begin
          sck_p[k]  = ~cpol;
          mosi_p[k] = word[width-1-b];
          #H;
          got = {got[30:0], miso_p[k]};
          sck_p[k] = cpol;
          #H;
        end
        first = 1'b0;
      end
      m_rx.push_back(got);
    end
    // mode 0: final SCK return coincides with CS release
    sck_p[k] = cpol;
    cs_p[k]  = 1'b1;
    #(2*H);
  endtask

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] tx;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[4];
  int b_dv, b_ld, b_er, e_tx, e_rx;
  logic [7:0] pat;

  initial begin
    vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[3] = '{8'h69, 8'hC3, 8'h69, 8'hC3};
    for (int i = 0; i < 3; i++) begin
      tx_base[i] = 0;
      for (int j = 0; j < 256; j++) tx_list[i][j] = '0;
    end
    resetn = 1'b1;
    cs_p   = 3'b111;
    sck_p  = 3'b010;
    mosi_p = 3'b000;
    #1 resetn = 1'b0;
    #11;
    chk("reset miso",  {31'h0, miso_p[0]},    0);
    chk("reset rx_dv", {31'h0, rx_dv[0]},     0);
    chk("reset rxbyte", {24'h0, rx_byte0},    0);
    chk("reset txload", {31'h0, tx_load[0]},  0);
    chk("reset ferr",  {31'h0, frame_err[0]}, 0);
    chk("reset busy",  {29'h0, busy},         0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);

    // Single-word mode 0 frames
    for (int i = 0; i < 4; i++) begin
      b_dv = n_dv[0]; b_ld = n_load[0]; b_er = n_err[0];
      tx_list[0][0] = {24'h0, vecs[i].tx};
      tx_base[0] = n_load[0];
      m_tx.delete(); m_rx.delete();
      m_tx.push_back({24'h0, vecs[i].mosi});
      frame(0, 1'b0, 1'b0, 8, 1, 8);
      chk($sformatf("v%0d rx_byte", i), {24'h0, rx_byte0}, {24'h0, vecs[i].exp_rx});
      chk($sformatf("v%0d miso", i), m_rx[0], {24'h0, vecs[i].exp_miso});
      chk($sformatf("v%0d rx_dv count", i), n_dv[0] - b_dv, 1);
      chk($sformatf("v%0d tx_load count", i), n_load[0] - b_ld, 1);
      chk($sformatf("v%0d frame_err count", i), n_err[0] - b_er, 0);
    end

    // Two back-to-back words in one frame
    b_dv = n_dv[0]; b_ld = n_load[0]; b_er = n_err[0];
    tx_list[0][0] = 32'h81; tx_list[0][1] = 32'h7E;
    tx_base[0] = n_load[0];
    m_tx.delete(); m_rx.delete();
    m_tx.push_back(32'h12); m_tx.push_back(32'h34);
    frame(0, 1'b0, 1'b0, 8, 2, 8);
    chk("b2b rx_dv count", n_dv[0] - b_dv, 2);
    chk("b2b rx word0", rx_log[0][b_dv & 1023], 32'h12);
    chk("b2b rx word1", rx_log[0][(b_dv + 1) & 1023], 32'h34);
    chk("b2b miso word0", m_rx[0], 32'h81);
    chk("b2b miso word1", m_rx[1], 32'h7E);
    chk("b2b tx_load count", n_load[0] - b_ld, 2);
    chk("b2b frame_err count", n_err[0] - b_er, 0);

    // Mode 3, 16-bit
    b_dv = n_dv[1]; b_ld = n_load[1];
    tx_list[1][0] = 32'h1234;
    tx_base[1] = n_load[1];
    m_tx.delete(); m_rx.delete();
    m_tx.push_back(32'hBEEF);
    frame(1, 1'b1, 1'b1, 16, 1, 16);
    chk("m3 rx_byte", {16'h0, rx_byte1}, 32'hBEEF);
    chk("m3 miso", m_rx[0], 32'h1234);
    chk("m3 rx_dv count", n_dv[1] - b_dv, 1);
    chk("m3 tx_load count", n_load[1] - b_ld, 1);

    // Aborted word after 5 bits, then a full frame
    b_dv = n_dv[0]; b_er = n_err[0];
    m_tx.delete(); m_rx.delete();
    m_tx.push_back(32'hFF);
    frame(0, 1'b0, 1'b0, 8, 1, 5);
    chk("abort frame_err count", n_err[0] - b_er, 1);
    chk("abort rx_dv count", n_dv[0] - b_dv, 0);
    chk("abort rx_byte held", {24'h0, rx_byte0}, 32'h34);
    b_dv = n_dv[0]; b_er = n_err[0];
    m_tx.delete(); m_rx.delete();
    m_tx.push_back(32'h5A);
    frame(0, 1'b0, 1'b0, 8, 1, 8);
    chk("after abort rx_byte", {24'h0, rx_byte0}, 32'h5A);
    chk("after abort rx_dv count", n_dv[0] - b_dv, 1);
    chk("after abort frame_err count", n_err[0] - b_er, 0);

    // Reset mid-word with CS held low through release
    @(negedge clk);
    cs_p[0] = 1'b0;
    #H;
    for (int i = 0; i < 3; i++) begin
      mosi_p[0] = 1'b1; #H; sck_p[0] = 1'b1; #H; sck_p[0] = 1'b0;
    end
    #H;
    chk("midword busy", {31'h0, busy[0]}, 1);
    #3 resetn = 1'b0;
    #1;
    chk("midrst miso",   {31'h0, miso_p[0]},    0);
    chk("midrst rxbyte", {24'h0, rx_byte0},     0);
    chk("midrst busy",   {31'h0, busy[0]},      0);
    chk("midrst rx_dv",  {31'h0, rx_dv[0]},     0);
    chk("midrst txload", {31'h0, tx_load[0]},   0);
    chk("midrst ferr",   {31'h0, frame_err[0]}, 0);
    #16 resetn = 1'b1;
    @(negedge clk);
    b_dv = n_dv[0]; b_ld = n_load[0];
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      mosi_p[0] = pat[7-i]; #H; sck_p[0] = 1'b1; #H; sck_p[0] = 1'b0;
    end
    #(2*H);
    chk("unarmed rx_dv count", n_dv[0] - b_dv, 0);
    chk("unarmed tx_load count", n_load[0] - b_ld, 0);
    chk("unarmed busy", {31'h0, busy[0]}, 0);
    chk("unarmed rx_byte", {24'h0, rx_byte0}, 0);
    cs_p[0] = 1'b1;
    #(2*H);
    tx_list[0][0] = 32'h96;
    tx_base[0] = n_load[0];
    m_tx.delete(); m_rx.delete();
    m_tx.push_back(32'hC3);
    frame(0, 1'b0, 1'b0, 8, 1, 8);
    chk("post-reset rx_byte", {24'h0, rx_byte0}, 32'hC3);
    chk("post-reset miso", m_rx[0], 32'h96);

    // Mode 1, 256 back-to-back random words
    m_tx.delete(); m_rx.delete();
    for (int i = 0; i < 256; i++) begin
      m_tx.push_back(32'($urandom_range(0, 255)));
      tx_list[2][i] = 32'($urandom_range(0, 255));
    end
    tx_base[2] = n_load[2];
    b_dv = n_dv[2]; b_ld = n_load[2];
    frame(2, 1'b0, 1'b1, 8, 256, 8);
    e_tx = 0; e_rx = 0;
    for (int i = 0; i < 256; i++) begin
      if (m_rx[i] !== tx_list[2][i]) e_tx++;
      if (rx_log[2][(b_dv + i) & 1023] !== m_tx[i]) e_rx++;
    end
    chk("m1 miso word errors", e_tx, 0);
    chk("m1 mosi word errors", e_rx, 0);
    chk("m1 rx_dv count", n_dv[2] - b_dv, 256);
    chk("m1 tx_load count", n_load[2] - b_ld, 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
